// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL supervisor and its surroundings.
// The slave side is the sequencer itself. The master side is whoever drives
// the lock flag and the software restart request and consumes the resets.
// There is no valid/ready handshake here: locked is a level from the PLL.
// soft_reset is a level-or-pulse request sampled on every refclk edge.
// All outputs are registered levels.
interface pll_reset_sequencer_if #(
  parameter int NUM_DOMAINS = 3,
  parameter int STAT_W      = 8
);
  logic                   locked;
  logic                   soft_reset;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_rst;
  logic                   all_ready;
  logic [STAT_W-1:0]      lock_loss_count;
  logic [STAT_W-1:0]      retry_count;

  modport master (
    output locked,
    output soft_reset,
    input  pll_rst,
    input  domain_rst,
    input  all_ready,
    input  lock_loss_count,
    input  retry_count
  );

  modport slave (
    input  locked,
    input  soft_reset,
    output pll_rst,
    output domain_rst,
    output all_ready,
    output lock_loss_count,
    output retry_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor and staggered reset sequencer on the PLL reference clock.
// It holds the PLL in reset, waits for a filtered lock and then releases the
// domain resets one by one. Any lock loss, lock timeout or software request
// restarts the whole sequence.
module pll_reset_sequencer #(
  parameter int NUM_DOMAINS    = 3,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int LOCK_FILTER    = 256,
  parameter int STAGE_DELAY    = 64,
  parameter int CNT_W          = 24,
  parameter int STAT_W         = 8
) (
  input  logic                 refclk,
  input  logic                 rst,
  pll_reset_sequencer_if.slave bus,
  output logic [2:0]           state_dbg
);

  localparam int STG_W = $clog2(NUM_DOMAINS + 1);

  typedef enum logic [2:0] {
    S_PLL_RESET = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_FILTER    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  // Terminal counts; every timer starts at 0 and compares with equality.
  localparam logic [CNT_W-1:0]  T_PLL_END     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  T_TIMEOUT_END = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  T_FILTER_END  = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0]  T_STAGE_END   = CNT_W'(STAGE_DELAY - 1);
  localparam logic [STG_W-1:0]  LAST_STAGE    = STG_W'(NUM_DOMAINS - 1);
  localparam logic [STAT_W-1:0] STAT_MAX      = '1;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     timer;
  logic [CNT_W-1:0]     timer_nxt;
  logic [STG_W-1:0]     stage;
  logic [STG_W-1:0]     stage_nxt;

  logic                 locked_m;
  logic                 locked_s;

  logic                 lock_lost;
  logic                 bump_retry;
  logic                 bump_loss;

  logic                   pll_rst_q;
  logic                   pll_rst_nxt;
  logic [NUM_DOMAINS-1:0] domain_rst_q;
  logic [NUM_DOMAINS-1:0] domain_rst_nxt;
  logic                   all_ready_q;
  logic                   all_ready_nxt;
  logic [STAT_W-1:0]      loss_cnt_q;
  logic [STAT_W-1:0]      loss_cnt_nxt;
  logic [STAT_W-1:0]      retry_cnt_q;
  logic [STAT_W-1:0]      retry_cnt_nxt;

  // Two-flop synchroniser for the asynchronous PLL lock flag.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      locked_m <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      locked_m <= bus.locked;
      locked_s <= locked_m;
    end
  end

  // Losing lock only matters once domain resets have started to release.
  assign lock_lost = !locked_s && ((state == S_RELEASE) || (state == S_RUN));

  // FSM state register together with its timer and stage index.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state <= S_PLL_RESET;
      timer <= '0;
      stage <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      stage <= stage_nxt;
    end
  end

  // Next-state logic. Priority is soft reset, then lock loss, then timeout,
  // then ordinary timer progression.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer + CNT_W'(1);
    stage_nxt  = stage;
    bump_retry = 1'b0;
    bump_loss  = 1'b0;
    if (bus.soft_reset) begin
      state_nxt = S_PLL_RESET;
      timer_nxt = '0;
      stage_nxt = '0;
    end else if (lock_lost) begin
      state_nxt = S_PLL_RESET;
      timer_nxt = '0;
      stage_nxt = '0;
      bump_loss = 1'b1;
    end else begin
      case (state)
        S_PLL_RESET: begin
          if (timer == T_PLL_END) begin
            state_nxt = S_WAIT_LOCK;
            timer_nxt = '0;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state_nxt = S_FILTER;
            timer_nxt = '0;
          end else if (timer == T_TIMEOUT_END) begin
            state_nxt  = S_PLL_RESET;
            timer_nxt  = '0;
            bump_retry = 1'b1;
          end
        end
        S_FILTER: begin
          // A dropout during filtering goes back to waiting with a fresh
          // timeout; it is not counted as a retry.
          if (!locked_s) begin
            state_nxt = S_WAIT_LOCK;
            timer_nxt = '0;
          end else if (timer == T_FILTER_END) begin
            state_nxt = S_RELEASE;
            timer_nxt = '0;
            stage_nxt = '0;
          end
        end
        S_RELEASE: begin
          if (timer == T_STAGE_END) begin
            timer_nxt = '0;
            stage_nxt = stage + STG_W'(1);
            if (stage == LAST_STAGE) begin
              state_nxt = S_RUN;
            end
          end
        end
        S_RUN: begin
          // The timer is idle in RUN; holding it avoids a free-running wrap.
          timer_nxt = timer;
        end
        default: begin
          state_nxt = S_PLL_RESET;
          timer_nxt = '0;
          stage_nxt = '0;
        end
      endcase
    end
  end

  // Output decode from the next state, so that every output is registered
  // and changes on the same edge as the state. Released bits are exactly
  // those below the next stage index, so they are always a low-order run.
  always_comb begin
    pll_rst_nxt   = (state_nxt == S_PLL_RESET);
    all_ready_nxt = (state_nxt == S_RUN);
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      domain_rst_nxt[i] = !((state_nxt == S_RUN) ||
                            ((state_nxt == S_RELEASE) && (STG_W'(i) < stage_nxt)));
    end
    loss_cnt_nxt  = loss_cnt_q;
    retry_cnt_nxt = retry_cnt_q;
    if (bump_loss && (loss_cnt_q != STAT_MAX)) begin
      loss_cnt_nxt = loss_cnt_q + STAT_W'(1);
    end
    if (bump_retry && (retry_cnt_q != STAT_MAX)) begin
      retry_cnt_nxt = retry_cnt_q + STAT_W'(1);
    end
  end

  // Output and status counter registers.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst_q    <= 1'b1;
      domain_rst_q <= '1;
      all_ready_q  <= 1'b0;
      loss_cnt_q   <= '0;
      retry_cnt_q  <= '0;
    end else begin
      pll_rst_q    <= pll_rst_nxt;
      domain_rst_q <= domain_rst_nxt;
      all_ready_q  <= all_ready_nxt;
      loss_cnt_q   <= loss_cnt_nxt;
      retry_cnt_q  <= retry_cnt_nxt;
    end
  end

  assign bus.pll_rst         = pll_rst_q;
  assign bus.domain_rst      = domain_rst_q;
  assign bus.all_ready       = all_ready_q;
  assign bus.lock_loss_count = loss_cnt_q;
  assign bus.retry_count     = retry_cnt_q;
  assign state_dbg           = state;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Parametrised PLL supervisor and reset sequencer running on the PLL reference clock. It drives the PLL reset and filters the asynchronous `locked` flag. It releases `NUM_DOMAINS` downstream resets in a fixed staggered order, and restarts the whole sequence on lock timeout, lock loss or software request. It sits beside the PLL wrapper in the top level; per-domain synchronisation of `domain_rst` into each output clock is done at the consumers.

## Interface
- `NUM_DOMAINS`, 3, number of staged domain resets (1..16).
- `PLL_RST_CYCLES`, 16, refclk cycles `pll_rst` is held high per attempt (≥2).
- `LOCK_TIMEOUT`, 65536, refclk cycles to wait for lock before retrying (≥2).
- `LOCK_FILTER`, 256, consecutive cycles synchronised lock must stay high before release (≥1).
- `STAGE_DELAY`, 64, refclk cycles between successive domain releases (≥1).
- `CNT_W`, 24, internal timer width; must hold max(parameters above) − 1.
- `STAT_W`, 8, width of the status counters.

Ports:
- `refclk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `locked` in 1: PLL lock, asynchronous; 2-flop synchronised internally (`locked_s`).
- `soft_reset` in 1: synchronous request to restart the full sequence; level or pulse.
- `pll_rst` out 1: PLL reset, registered.
- `domain_rst` out NUM_DOMAINS: active-high domain resets, registered; bit 0 released first.
- `all_ready` out 1: high only in RUN.
- `lock_loss_count` out STAT_W: saturating count of lock losses after release started.
- `retry_count` out STAT_W: saturating count of lock timeouts.

## Operation
- States: PLL_RESET, WAIT_LOCK, FILTER, RELEASE, RUN.
- Reset values:
  - state PLL_RESET, timer 0, stage 0.
  - `pll_rst`=1, `domain_rst`=all ones, `all_ready`=0.
  - both counters 0, synchroniser flops 0.
- PLL_RESET: `pll_rst`=1. Timer counts 0..PLL_RST_CYCLES−1, then WAIT_LOCK with timer cleared.
- WAIT_LOCK: `pll_rst`=0.
  - `locked_s`=1 → FILTER, timer 0.
  - Else, at timer=LOCK_TIMEOUT−1 → PLL_RESET and `retry_count`+1.
- FILTER: `locked_s`=0 → WAIT_LOCK, timer 0. The timeout restarts and this is not a retry. At timer=LOCK_FILTER−1 → RELEASE, timer 0, stage 0.
- RELEASE: at timer=STAGE_DELAY−1, clear `domain_rst[stage]`, stage+1, timer 0. Clearing bit NUM_DOMAINS−1 enters RUN on the same edge.
- RUN: `all_ready`=1. `domain_rst`=0 held.
- Lock loss: `locked_s`=0 in RELEASE or RUN has the following effects on the next edge.
  - `domain_rst` goes to all ones and `all_ready` to 0.
  - `lock_loss_count` increments, saturating at 2^STAT_W−1.
  - State → PLL_RESET, timer 0.
- `soft_reset`=1 in any state has the same effect as lock loss, without incrementing any counter. In PLL_RESET it restarts the timer, so `pll_rst` stays high while `soft_reset` is held.
- Priority: `soft_reset` > lock loss > timeout > timer progression.
- Invariants:
  - Released bits form a contiguous low-order run of zeros.
  - `pll_rst`=1 implies `domain_rst` all ones.
  - Counters never wrap.
- `rst` mid-sequence forces the reset values immediately, asynchronously.

## Timing
- All outputs are registered. Timers are CNT_W wide and compare with equality.
- `locked` to `locked_s`: 2 edges of latency.
- After `rst` deasserts, `pll_rst` stays high for exactly PLL_RST_CYCLES rising edges.
- Release schedule: let L be the edge at which `locked_s` first reads 1 in WAIT_LOCK.
  - FILTER is entered at L.
  - `domain_rst[i]` falls at L + LOCK_FILTER + (i+1)·STAGE_DELAY.
  - `all_ready` rises on the same edge as the last bit.
- Lock loss or `soft_reset` to `domain_rst` all ones and `pll_rst`=1: 1 edge after detection. Lock loss is detected 2 edges after `locked` falls, because of the synchroniser.
- Timeout retry period: PLL_RST_CYCLES + LOCK_TIMEOUT cycles.

## Test plan
Bench parameters: NUM_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, LOCK_FILTER=8, STAGE_DELAY=5, STAT_W=4.

- Clean start: release `rst`, raise `locked` 10 cycles later. Required: `pll_rst` high for 4 cycles; `domain_rst` bits fall at L+13, L+18, L+23; `all_ready` rises at L+23; counters 0.
- Timeout: hold `locked`=0. Required: `pll_rst` pulses of 4 cycles every 36 cycles; `retry_count` increments per retry and saturates at 15 after 15 retries.
- Filter glitch: `locked` high for 5 cycles, low for 1, then high. Required: no release before 8 consecutive high `locked_s` cycles; schedule restarts from the second rise.
- Lock loss in RUN, then again mid-RELEASE after only bit 0 is released. Required in both cases: `domain_rst`=3'b111 and `pll_rst`=1 one edge after `locked_s` falls; `lock_loss_count` reaches 2.
- `soft_reset` for 1 cycle in RUN, then held for 10 cycles. Required: full restart with counters unchanged; `pll_rst` stays high until 4 cycles after `soft_reset` drops.
- Async `rst` asserted between edges mid-RELEASE. Required: all outputs at reset values before the next edge.
